// File: rtl/raster_mem_writer_pkg.sv
// Shared types and helpers for the raster scanner memory writer.
// Widths here are kept in step with the raster block.
package raster_mem_writer_pkg;

    localparam int MAX_ADC_DATA_WID = 24;
    localparam int STATE_WID = 2;

    typedef enum logic [STATE_WID-1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        WRITE  = 2'd2
    } state_t;

    // Replicate bit w-1 of v into all higher bits.
    function automatic logic [63:0] sign_ext(input logic [63:0] v,
                                             input int w);
        logic [63:0] hi;
        logic        sgn;
        hi  = ~64'd0 << w;
        sgn = |(v & (64'd1 << (w - 1)));
        return sgn ? (v | hi) : (v & ~hi);
    endfunction

endpackage

// File: rtl/raster_mem_writer_sync_fifo.sv
// Single-clock FIFO with registered read data and occupancy count.
// Full/empty come straight from the count register, no bypass.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                rdata  <= mem[rd_ptr];
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/raster_mem_writer.sv
// Buffers scanner samples and writes them as sign-extended words
// into a circular or bounded memory window over a stb/ack bus.
module raster_mem_writer
    import raster_mem_writer_pkg::*;
#(
    parameter int DAT_WID    = MAX_ADC_DATA_WID,
    parameter int BUS_WID    = 32,
    parameter int ADDR_WID   = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int WORDS_WID  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arm,
    output logic                          running,
    input  logic [ADDR_WID-1:0]           base_addr_in,
    input  logic [WORDS_WID-1:0]          window_words_in,
    input  logic                          wrap_en_in,
    input  logic [DAT_WID-1:0]            data,
    input  logic                          mem_commit,
    output logic                          mem_finished,
    output logic [ADDR_WID-1:0]           bus_addr,
    output logic [BUS_WID-1:0]            bus_data,
    output logic                          bus_stb,
    input  logic                          bus_ack,
    output logic [WORDS_WID-1:0]          words_written,
    output logic                          wrapped,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [WORDS_WID-1:0] ONE  = WORDS_WID'(1);
    localparam logic [WORDS_WID-1:0] MAXW = '1;

    state_t               state;
    state_t               state_n;
    logic                 arm_q;
    logic                 start;
    logic                 pop;
    logic                 discard;
    logic                 wr_done;
    logic                 accept;
    logic                 full;
    logic                 empty;
    logic [ADDR_WID-1:0]  base;
    logic [WORDS_WID-1:0] win;
    logic [WORDS_WID-1:0] idx;
    logic                 wrap;
    logic                 win_done;
    logic [DAT_WID-1:0]   sample;

    assign running  = (state != IDLE);
    assign bus_stb  = (state == WRITE);
    assign accept   = mem_commit && !mem_finished && !full && running && arm;
    assign bus_addr = base + (ADDR_WID'(idx) << 2);
    assign bus_data = BUS_WID'(sign_ext(64'(sample), DAT_WID));

    sync_fifo #(
        .WIDTH(DAT_WID),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (accept),
        .wdata(data),
        .pop  (pop),
        .rdata(sample),
        .full (full),
        .empty(empty),
        .level(fifo_level)
    );

    always_comb begin
        state_n = state;
        start   = 1'b0;
        pop     = 1'b0;
        discard = 1'b0;
        wr_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm && !arm_q) begin
                    start   = 1'b1;
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (!wrap && win_done) discard = 1'b1;
                    else state_n = WRITE;
                end else if (!arm) begin
                    state_n = IDLE;
                end
            end
            WRITE: begin
                if (bus_ack) begin
                    wr_done = 1'b1;
                    state_n = ACTIVE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            arm_q <= 1'b0;
        end else begin
            state <= state_n;
            arm_q <= arm;
        end
    end

    // Acknowledge stays up until the scanner drops its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_finished <= 1'b0;
        else if (accept) mem_finished <= 1'b1;
        else if (!mem_commit) mem_finished <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base          <= '0;
            win           <= ONE;
            wrap          <= 1'b0;
            idx           <= '0;
            win_done      <= 1'b0;
            words_written <= '0;
            wrapped       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (start) begin
                base          <= base_addr_in;
                win           <= (window_words_in == '0) ? ONE : window_words_in;
                wrap          <= wrap_en_in;
                idx           <= '0;
                win_done      <= 1'b0;
                words_written <= '0;
                wrapped       <= 1'b0;
                overflow      <= 1'b0;
            end
            if (discard) overflow <= 1'b1;
            if (wr_done) begin
                if (words_written != MAXW) words_written <= words_written + ONE;
                if (idx == win - ONE) begin
                    idx <= '0;
                    if (wrap) wrapped <= 1'b1;
                    else win_done <= 1'b1;
                end else begin
                    idx <= idx + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_raster_mem_writer.sv
// Scoreboard bench for raster_mem_writer: driver pushes expected
// writes from a window model, a negedge monitor checks bus writes.
module tb_raster_mem_writer;

    localparam int DW = 24;
    localparam int BW = 32;
    localparam int AW = 32;
    localparam int FD = 8;
    localparam int WW = 16;
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          running;
    logic [AW-1:0] base_addr_in = '0;
    logic [WW-1:0] window_words_in = '0;
    logic          wrap_en_in = 1'b0;
    logic [DW-1:0] data = '0;
    logic          mem_commit = 1'b0;
    logic          mem_finished;
    logic [AW-1:0] bus_addr;
    logic [BW-1:0] bus_data;
    logic          bus_stb;
    logic          bus_ack = 1'b0;
    logic [WW-1:0] words_written;
    logic          wrapped;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    raster_mem_writer #(
        .DAT_WID(DW), .BUS_WID(BW), .ADDR_WID(AW),
        .FIFO_DEPTH(FD), .WORDS_WID(WW)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .running(running),
        .base_addr_in(base_addr_in), .window_words_in(window_words_in),
        .wrap_en_in(wrap_en_in), .data(data), .mem_commit(mem_commit),
        .mem_finished(mem_finished), .bus_addr(bus_addr),
        .bus_data(bus_data), .bus_stb(bus_stb), .bus_ack(bus_ack),
        .words_written(words_written), .wrapped(wrapped),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit hold_ack = 1'b0;
    int ack_pct = 100;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    logic [31:0] m_base;
    int          m_win;
    bit          m_wrap;
    int          m_acc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference window model: what one accepted sample should produce.
    task automatic model_accept(input logic [DW-1:0] d);
        logic [31:0] a;
        logic [31:0] w;
        w = {{8{d[DW-1]}}, d};
        if (m_wrap || m_acc < m_win) begin
            a = m_base + 32'((m_acc % m_win) * 4);
            exp_q.push_back({a, w});
        end
        m_acc++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus_ack = !hold_ack && ($urandom_range(0, 99) < ack_pct);
        end
    end

    always @(negedge clk) begin
        if (!rst && bus_stb === 1'b1 && bus_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                         bus_addr, bus_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", 64'(bus_addr), 64'(mon_e[63:32]));
                chk("write_data", 64'(bus_data), 64'(mon_e[31:0]));
            end
        end
    end

    task automatic start(input logic [31:0] b, input int w, input bit wr);
        base_addr_in    = b;
        window_words_in = WW'(w);
        wrap_en_in      = wr;
        arm             = 1'b1;
        m_base = b;
        m_win  = (w == 0) ? 1 : w;
        m_wrap = wr;
        m_acc  = 0;
        @(posedge clk);
        #1;
        chk("running_after_arm", 64'(running), 64'd1);
    endtask

    task automatic commit_wait(input logic [DW-1:0] d, input int tmo,
                               output bit ok, output int cyc);
        data       = d;
        mem_commit = 1'b1;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < tmo) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_finished) ok = 1'b1;
        end
    endtask

    task automatic commit_finish(input logic [DW-1:0] d);
        model_accept(d);
        mem_commit = 1'b0;
        @(posedge clk);
        #1;
        chk("finished_clear", 64'(mem_finished), 64'd0);
    endtask

    task automatic send(input logic [DW-1:0] d, input int tmo);
        bit ok;
        int cyc;
        commit_wait(d, tmo, ok, cyc);
        chk("commit_ack", 64'(ok), 64'd1);
        if (ok) begin
            commit_finish(d);
        end else begin
            mem_commit = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int tmo);
        int c;
        int exp_w;
        arm = 1'b0;
        c = 0;
        while (running && c < tmo) begin
            @(posedge clk);
            #1;
            c++;
        end
        exp_w = m_wrap ? m_acc : ((m_acc < m_win) ? m_acc : m_win);
        chk("drained", 64'(running), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("words_written", 64'(words_written), 64'(exp_w));
        chk("wrapped", 64'(wrapped), 64'(m_wrap && m_acc >= m_win));
        chk("overflow", 64'(overflow), 64'(!m_wrap && m_acc > m_win));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, limit reached");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          cyc;
        int          n;
        logic [DW-1:0] d;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_stb", 64'(bus_stb), 64'd0);
        chk("rst_finished", 64'(mem_finished), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_words", 64'(words_written), 64'd0);
        chk("rst_flags", 64'({wrapped, overflow}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Not armed: commit must never be acknowledged.
        commit_wait(24'h123456, 6, ok, cyc);
        chk("idle_no_ack", 64'(ok), 64'd0);
        mem_commit = 1'b0;
        @(posedge clk);
        #1;

        // Single sample, ack latency.
        start(32'h1000, 4, 1'b1);
        commit_wait(24'h800001, 10, ok, cyc);
        chk("single_ack", 64'(ok), 64'd1);
        chk("finished_latency", 64'(cyc), 64'd1);
        if (ok) commit_finish(24'h800001);
        drain(100);

        // Circular wrap.
        start(32'h1000, 3, 1'b1);
        for (int i = 0; i < 5; i++) send(DW'($urandom), 50);
        drain(200);

        // Bounded overflow.
        start(32'h1000, 2, 1'b0);
        for (int i = 0; i < 4; i++) send(DW'($urandom), 50);
        drain(200);

        // Window length 0 behaves as 1.
        start(32'h5000, 0, 1'b1);
        for (int i = 0; i < 3; i++) send(DW'($urandom), 50);
        drain(200);

        // Backpressure: fill until the acknowledge is withheld.
        start(32'h2000, 16, 1'b1);
        hold_ack = 1'b1;
        n  = 0;
        ok = 1'b1;
        d  = '0;
        while (ok && n < 12) begin
            d = DW'($urandom);
            commit_wait(d, 15, ok, cyc);
            if (ok) begin
                commit_finish(d);
                n++;
            end
        end
        chk("bp_accepted", 64'(n), 64'(FD + 1));
        chk("bp_level", 64'(fifo_level), 64'(FD));
        hold_ack = 1'b0;
        commit_wait(d, 100, ok, cyc);
        chk("bp_late_ack", 64'(ok), 64'd1);
        if (ok) commit_finish(d);
        else mem_commit = 1'b0;
        send(DW'($urandom), 100);
        drain(500);

        // Drain on disarm.
        start(32'h3000, 8, 1'b0);
        hold_ack = 1'b1;
        for (int i = 0; i < 3; i++) send(DW'($urandom), 50);
        arm = 1'b0;
        commit_wait(DW'($urandom), 10, ok, cyc);
        chk("disarm_no_ack", 64'(ok), 64'd0);
        chk("running_while_queued", 64'(running), 64'd1);
        mem_commit = 1'b0;
        hold_ack   = 1'b0;
        drain(200);

        // Randomized windows and bus latency.
        ack_pct = 40;
        for (int r = 0; r < 4; r++) begin
            start($urandom & ~32'h3, $urandom_range(0, 6), 1'($urandom));
            n = $urandom_range(4, 14);
            for (int i = 0; i < n; i++) send(DW'($urandom), 300);
            drain(3000);
        end
        ack_pct = 100;

        // Reset in the middle of a write.
        start(32'h4000, 4, 1'b1);
        hold_ack = 1'b1;
        for (int i = 0; i < 2; i++) send(DW'($urandom), 50);
        commit_wait(DW'($urandom), 10, ok, cyc);
        chk("pre_rst_ack", 64'(ok), 64'd1);
        chk("pre_rst_stb", 64'(bus_stb), 64'd1);
        arm = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_stb", 64'(bus_stb), 64'd0);
        chk("mid_rst_finished", 64'(mem_finished), 64'd0);
        chk("mid_rst_running", 64'(running), 64'd0);
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        mem_commit = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        hold_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_stb", 64'(bus_stb), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
